rgb_fade_pwm: RTL and testbench
===============================

# rgb_fade_pwm

Three-channel LED fade driver placed directly downstream of the `blink` block. It consumes the on/off `led_r`/`led_g`/`led_b` levels that `blink` produces. Each on/off edge is turned into a linear brightness ramp, and the ramped level drives a PWM output per channel. The PWM outputs connect to the board RGB LED pins in place of the raw blink signals.

## Interface
- `PWM_BITS`, 8: PWM and brightness resolution. `MAX_LEVEL` is 2^PWM_BITS−1.
- `FADE_DIV`, 1024: clock cycles per brightness step. Must be ≥2.
- `INVERT`, 0: when 1, `pwm_*` outputs are active-low.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `en`  in  1  fade enable; 0 freezes the brightness levels, PWM keeps running
- `led_r_in`, `led_g_in`, `led_b_in`  in  1 each  on/off request from `blink`, synchronous to `clk`
- `pwm_r`, `pwm_g`, `pwm_b`  out  1 each  registered PWM drive
- `level_r`, `level_g`, `level_b`  out  PWM_BITS each  current brightness
- `busy`  out  1  high while any channel is in RISE or FALL

## Operation
- **Input stage:** each `led_*_in` is registered once into `in_q`.
- **PWM counter `pwm_cnt`:**
  - Width PWM_BITS, free-running, +1 every cycle.
  - Wraps from MAX_LEVEL to 0.
- **Prescaler `div_cnt`:**
  - Counts 0..FADE_DIV−1, advancing only while `en`=1; holds its value while `en`=0.
  - `tick` is high for exactly one cycle when `div_cnt`=FADE_DIV−1 and `en`=1; `div_cnt` then wraps to 0.
- **Per-channel FSM**, states OFF, RISE, ON, FALL:
  - OFF→RISE when `in_q`=1.
  - RISE→FALL when `in_q`=0 (reversal; ramp continues from the current level, no jump).
  - RISE→ON on a tick where the level becomes MAX_LEVEL.
  - ON→FALL when `in_q`=0.
  - FALL→RISE when `in_q`=1.
  - FALL→OFF on a tick where the level becomes 0.
  - Reversal has priority over completion in the same cycle.
- **Level update:**
  - On `tick`, RISE does level+1 and FALL does level−1, using the state registered before that edge. OFF and ON hold.
  - Level saturates at 0 and MAX_LEVEL; it never wraps.
- **PWM compare:**
  - raw = (level==MAX_LEVEL) or (level > pwm_cnt).
  - `pwm_*` <= raw XOR INVERT.
  - Level 0 gives 0% duty. Level L (0<L<MAX_LEVEL) gives L high cycles per 2^PWM_BITS. MAX_LEVEL gives 100%.
- **`busy`:** registered OR of (state ∈ {RISE, FALL}) over all three channels.

## Timing
- **Reset values:**
  - `pwm_cnt`, `div_cnt`, `in_q`, all levels: 0.
  - All states: OFF.
  - `busy`: 0. `level_*`: 0. `pwm_*`: INVERT.
  - Reset asserted mid-ramp aborts the ramp immediately. There is no ramp-down after reset.
- **Input latency:**
  - `led_*_in` change at edge t is visible in `in_q` at t+1.
  - The state changes at t+2.
  - The first level step occurs on the next tick after that.
- **Ramp length:** a full ramp 0→MAX_LEVEL takes MAX_LEVEL ticks, i.e. MAX_LEVEL×FADE_DIV cycles (±one prescaler phase at start).
- **Output latency:**
  - `pwm_*` lags `level`/`pwm_cnt` by one cycle.
  - `busy` lags state by one cycle.
- **Same-edge events:**
  - Input reversal on the same edge as a tick: the step goes in the old direction and the state switches on that edge.
  - Reversal on the tick that would complete the ramp: the level reaches the end value and the state goes to the opposite ramp.
- **Enable:** `en`=0 freezes levels and states' progress. State transitions on input still occur. `pwm_cnt` keeps counting.
- **Channel independence:** channels are fully independent and share only `pwm_cnt` and `tick`.

## Test plan
All scenarios use PWM_BITS=4 (MAX_LEVEL 15) and FADE_DIV=4.

- **Reset mid-ramp:** drive `led_r_in`=1, wait 20 cycles, pulse `rst`. Required: `level_r`=0, `pwm_r`=0 and `busy`=0 immediately (asynchronously); after reset release `level_r` ramps from 0 again.
- **Full rise:** step `led_r_in` 0→1 and hold.
  - `level_r` increments once every 4 cycles and reaches 15 after 60 cycles ±4.
  - `busy` falls one cycle after the state reaches ON.
  - From then on `pwm_r` is constantly 1.
  - `level_g`/`level_b` stay 0.
- **Duty:** ramp `level_g` to 5, then set `en`=0. Required: `pwm_g` is high exactly 5 of every 16 cycles, and `level_g` stays at 5.
- **Reversal:** rise `level_b` to 7, then drop `led_b_in`. Required: sequence 7,6,…,0 with no jump, state ends OFF, and `busy` ends 0. A reversal back to 1 at level 3 resumes 3,4,….
- **INVERT=1 with all channels:** drive r=1, g=0, b=1. Required: `pwm_g` stays 1, `pwm_r`/`pwm_b` reach constant 0 at level 15, and after reset all `pwm_*` are 1.

Source files
------------

// File: rtl/rgb_fade_pwm.sv
// Three-channel LED fader: on/off requests become linear brightness ramps
// that drive one registered PWM output per channel.
module rgb_fade_pwm #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 1024,
    parameter bit INVERT   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                led_r_in,
    input  logic                led_g_in,
    input  logic                led_b_in,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic [PWM_BITS-1:0] level_r,
    output logic [PWM_BITS-1:0] level_g,
    output logic [PWM_BITS-1:0] level_b,
    output logic                busy
);
    // state   | meaning
    // ST_OFF  | dark, level held at 0
    // ST_RISE | level steps up once per tick
    // ST_ON   | fully lit, level held at MAX_LEVEL
    // ST_FALL | level steps down once per tick
    typedef enum logic [1:0] {ST_OFF, ST_RISE, ST_ON, ST_FALL} state_t;

    localparam int                  DIV_W     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                w_tick;
    logic [2:0]          w_led_in;
    logic [2:0]          r_in_q;
    logic [2:0]          r_pwm;
    logic [2:0]          w_raw;
    logic [2:0]          w_active;
    logic                r_busy;
    state_t              r_state     [3];
    state_t              w_state_nxt [3];
    logic [PWM_BITS-1:0] r_level     [3];
    logic [PWM_BITS-1:0] w_level_nxt [3];

    assign w_led_in = {led_b_in, led_g_in, led_r_in};
    assign w_tick   = en && (r_div_cnt == DIV_W'(FADE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
            r_in_q    <= '0;
            r_pwm     <= {3{INVERT}};
            r_busy    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= ST_OFF;
                r_level[i] <= '0;
            end
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (en) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            end
            r_in_q <= w_led_in;
            r_pwm  <= w_raw ^ {3{INVERT}};
            r_busy <= |w_active;
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_level[i] <= w_level_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_level_nxt[i] = r_level[i];
            w_state_nxt[i] = r_state[i];
            // Step direction follows the state held before the edge; ends saturate
            if (w_tick) begin
                if (r_state[i] == ST_RISE && r_level[i] != MAX_LEVEL) begin
                    w_level_nxt[i] = r_level[i] + PWM_BITS'(1);
                end else if (r_state[i] == ST_FALL && r_level[i] != '0) begin
                    w_level_nxt[i] = r_level[i] - PWM_BITS'(1);
                end
            end
            case (r_state[i])
                ST_OFF: begin
                    if (r_in_q[i]) w_state_nxt[i] = ST_RISE;
                end
                ST_RISE: begin
                    if (!r_in_q[i])                                    w_state_nxt[i] = ST_FALL;
                    else if (w_tick && w_level_nxt[i] == MAX_LEVEL)    w_state_nxt[i] = ST_ON;
                end
                ST_ON: begin
                    if (!r_in_q[i]) w_state_nxt[i] = ST_FALL;
                end
                ST_FALL: begin
                    if (r_in_q[i])                                     w_state_nxt[i] = ST_RISE;
                    else if (w_tick && w_level_nxt[i] == '0)           w_state_nxt[i] = ST_OFF;
                end
                default: w_state_nxt[i] = ST_OFF;
            endcase
            w_active[i] = (r_state[i] == ST_RISE) || (r_state[i] == ST_FALL);
            w_raw[i]    = (r_level[i] == MAX_LEVEL) || (r_level[i] > r_pwm_cnt);
        end
    end

    assign pwm_r   = r_pwm[0];
    assign pwm_g   = r_pwm[1];
    assign pwm_b   = r_pwm[2];
    assign level_r = r_level[0];
    assign level_g = r_level[1];
    assign level_b = r_level[2];
    assign busy    = r_busy;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm: a level-change monitor pops expected brightness
// values from per-channel queues filled by the directed stimulus.
module tb_rgb_fade_pwm;
    localparam int PB = 4;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       rin = 1'b0, gin = 1'b0, bin = 1'b0;
    logic       pwm_r, pwm_g, pwm_b, busy;
    logic [3:0] level_r, level_g, level_b;

    logic       rst_i = 1'b1;
    logic       irin = 1'b0, igin = 1'b0, ibin = 1'b0;
    logic       ipwm_r, ipwm_g, ipwm_b, ibusy;
    logic [3:0] ilevel_r, ilevel_g, ilevel_b;

    int n_checks = 0;
    int n_errors = 0;
    int q_r[$];
    int q_g[$];
    int q_b[$];
    logic [3:0] prev_r = 4'd0, prev_g = 4'd0, prev_b = 4'd0;

    always #5 clk = ~clk;

    rgb_fade_pwm #(.PWM_BITS(PB), .FADE_DIV(FD), .INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en),
        .led_r_in(rin), .led_g_in(gin), .led_b_in(bin),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
        .level_r(level_r), .level_g(level_g), .level_b(level_b),
        .busy(busy)
    );

    rgb_fade_pwm #(.PWM_BITS(PB), .FADE_DIV(FD), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst_i), .en(1'b1),
        .led_r_in(irin), .led_g_in(igin), .led_b_in(ibin),
        .pwm_r(ipwm_r), .pwm_g(ipwm_g), .pwm_b(ipwm_b),
        .level_r(ilevel_r), .level_g(ilevel_g), .level_b(ilevel_b),
        .busy(ibusy)
    );

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic int cur_level(input int ch);
        case (ch)
            0:       return int'(level_r);
            1:       return int'(level_g);
            2:       return int'(level_b);
            default: return int'(ilevel_r);
        endcase
    endfunction

    task automatic wait_level(input string nm, input int ch, input int val, input int limit);
        int cyc;
        cyc = 0;
        while (cur_level(ch) != val && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check(nm, cur_level(ch), val);
    endtask

    // Every brightness change must match the next queued value (-1 = none expected)
    always @(negedge clk) begin
        if (level_r != prev_r) begin
            check("sb level_r", int'(level_r), (q_r.size() == 0) ? -1 : q_r.pop_front());
            prev_r = level_r;
        end
        if (level_g != prev_g) begin
            check("sb level_g", int'(level_g), (q_g.size() == 0) ? -1 : q_g.pop_front());
            prev_g = level_g;
        end
        if (level_b != prev_b) begin
            check("sb level_b", int'(level_b), (q_b.size() == 0) ? -1 : q_b.pop_front());
            prev_b = level_b;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, last, seen, hr, hg, hb;

        repeat (3) @(negedge clk);
        check("rst level_r", level_r, 0);
        check("rst level_g", level_g, 0);
        check("rst level_b", level_b, 0);
        check("rst pwm_r", pwm_r, 0);
        check("rst pwm_g", pwm_g, 0);
        check("rst pwm_b", pwm_b, 0);
        check("rst busy", busy, 0);
        check("rst inv pwm_r", ipwm_r, 1);
        check("rst inv pwm_g", ipwm_g, 1);
        check("rst inv pwm_b", ipwm_b, 1);

        // reset mid-ramp: steps land on edges 4,8,..,20 after release
        for (int v = 1; v <= 5; v++) q_r.push_back(v);
        rst = 1'b0;
        rin = 1'b1;
        repeat (20) @(negedge clk);
        check("mid-ramp level_r", level_r, 5);
        check("mid-ramp busy", busy, 1);
        q_r.push_back(0);
        #1 rst = 1'b1;
        #1;
        check("async rst level_r", level_r, 0);
        check("async rst pwm_r", pwm_r, 0);
        check("async rst busy", busy, 0);
        repeat (2) @(negedge clk);

        // full rise from 0 to 15
        for (int v = 1; v <= 15; v++) q_r.push_back(v);
        rst = 1'b0;
        cyc = 0; last = 0; seen = 0;
        while (level_r != 4'd15 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (int'(level_r) != seen) begin
                if (seen != 0) check("step spacing", cyc - last, FD);
                last = cyc;
                seen = int'(level_r);
            end
        end
        check("rise reached", level_r, 15);
        check("rise time in 56..64", int'(cyc >= 56 && cyc <= 64), 1);
        check("busy on ON edge", busy, 1);
        @(negedge clk);
        check("busy after ON", busy, 0);
        hr = 0;
        repeat (32) begin @(negedge clk); hr += int'(pwm_r); end
        check("pwm_r full on", hr, 32);
        check("level_g idle", level_g, 0);
        check("level_b idle", level_b, 0);

        // duty at level 5 with fade frozen
        for (int v = 1; v <= 5; v++) q_g.push_back(v);
        gin = 1'b1;
        wait_level("g reach 5", 1, 5, 60);
        en = 1'b0;
        repeat (8) @(negedge clk);
        hg = 0;
        repeat (16) begin @(negedge clk); hg += int'(pwm_g); end
        check("duty pwm_g", hg, 5);
        repeat (20) @(negedge clk);
        check("frozen level_g", level_g, 5);
        check("busy frozen", busy, 1);
        en = 1'b1;
        for (int v = 4; v >= 0; v--) q_g.push_back(v);
        gin = 1'b0;
        wait_level("g back to 0", 1, 0, 60);

        // reversal on b
        for (int v = 1; v <= 7; v++) q_b.push_back(v);
        bin = 1'b1;
        wait_level("b reach 7", 2, 7, 60);
        for (int v = 6; v >= 0; v--) q_b.push_back(v);
        bin = 1'b0;
        wait_level("b fall 0", 2, 0, 60);
        check("busy at OFF edge", busy, 1);
        @(negedge clk);
        check("busy idle", busy, 0);
        for (int v = 1; v <= 6; v++) q_b.push_back(v);
        bin = 1'b1;
        wait_level("b reach 6", 2, 6, 60);
        for (int v = 5; v >= 3; v--) q_b.push_back(v);
        bin = 1'b0;
        wait_level("b fall 3", 2, 3, 60);
        for (int v = 4; v <= 7; v++) q_b.push_back(v);
        bin = 1'b1;
        wait_level("b resume 7", 2, 7, 60);
        for (int v = 6; v >= 0; v--) q_b.push_back(v);
        bin = 1'b0;
        wait_level("b final 0", 2, 0, 60);
        repeat (2) @(negedge clk);
        check("busy end", busy, 0);
        check("q_r drained", q_r.size(), 0);
        check("q_g drained", q_g.size(), 0);
        check("q_b drained", q_b.size(), 0);

        // inverted outputs, r and b on, g off
        irin = 1'b1; ibin = 1'b1; igin = 1'b0;
        rst_i = 1'b0;
        wait_level("inv r reach 15", 3, 15, 100);
        repeat (2) @(negedge clk);
        hr = 0; hg = 0; hb = 0;
        repeat (32) begin
            @(negedge clk);
            hr += int'(ipwm_r);
            hg += int'(ipwm_g);
            hb += int'(ipwm_b);
        end
        check("inv pwm_r on", hr, 0);
        check("inv pwm_g off", hg, 32);
        check("inv pwm_b on", hb, 0);
        check("inv level_b", ilevel_b, 15);
        check("inv busy", ibusy, 0);
        rst_i = 1'b1;
        #1;
        check("inv rst pwm_r", ipwm_r, 1);
        check("inv rst pwm_g", ipwm_g, 1);
        check("inv rst pwm_b", ipwm_b, 1);
        check("inv rst level_r", ilevel_r, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
